// File: rtl/xform_lane_scheduler_if.sv
// xform_lane_scheduler_if
//   Handshake bundle for the lane scheduler: one residual input stream,
//   NUM_LANES residual/coefficient lane pairs, one merged coefficient output.
//   Every stream transfers on a rising clk edge when vld && rdy.
//
//   master : scheduler side
//   slave  : surroundings (residual source, transform lanes, coeff_cost stage)
interface xform_lane_scheduler_if #(
  parameter int NUM_LANES = 2,
  parameter int IN_W      = 288,
  parameter int OUT_W     = 512
);
  logic [IN_W-1:0]            resid_in_rsc_dat;
  logic                       resid_in_rsc_vld;
  logic                       resid_in_rsc_rdy;

  logic [NUM_LANES*IN_W-1:0]  lane_resid_rsc_dat;
  logic [NUM_LANES-1:0]       lane_resid_rsc_vld;
  logic [NUM_LANES-1:0]       lane_resid_rsc_rdy;

  logic [NUM_LANES*OUT_W-1:0] lane_coeff_rsc_dat;
  logic [NUM_LANES-1:0]       lane_coeff_rsc_vld;
  logic [NUM_LANES-1:0]       lane_coeff_rsc_rdy;

  logic [OUT_W-1:0]           coeff_out_rsc_dat;
  logic                       coeff_out_rsc_vld;
  logic                       coeff_out_rsc_rdy;

  modport master (
    input  resid_in_rsc_dat, resid_in_rsc_vld,
    output resid_in_rsc_rdy,
    output lane_resid_rsc_dat, lane_resid_rsc_vld,
    input  lane_resid_rsc_rdy,
    input  lane_coeff_rsc_dat, lane_coeff_rsc_vld,
    output lane_coeff_rsc_rdy,
    output coeff_out_rsc_dat, coeff_out_rsc_vld,
    input  coeff_out_rsc_rdy
  );

  modport slave (
    output resid_in_rsc_dat, resid_in_rsc_vld,
    input  resid_in_rsc_rdy,
    input  lane_resid_rsc_dat, lane_resid_rsc_vld,
    output lane_resid_rsc_rdy,
    output lane_coeff_rsc_dat, lane_coeff_rsc_vld,
    input  lane_coeff_rsc_rdy,
    input  coeff_out_rsc_dat, coeff_out_rsc_vld,
    output coeff_out_rsc_rdy
  );
endinterface

// File: rtl/xform_lane_scheduler.sv
// xform_lane_scheduler
//   Spreads whole residual blocks round-robin over NUM_LANES transform lanes
//   and merges the resulting coefficient blocks back in dispatch order.
//   Block size comes from the top two bits of a block's first residual beat:
//     code : in beats / out beats
//       0  :   1 / 1      (4x4)
//       1  :   4 / 2      (8x8)
//       2  :  16 / 8      (16x16)
//       3  :  64 / 32     (32x32)
//   A FIFO of dispatched size codes drives the collect side, so output order
//   never depends on which lane finishes first. Both paths are pure
//   combinational steering; no data is registered.
//
// Ports
//   clk            clock, rising edge
//   arst_n         asynchronous active-low reset (lanes share it)
//   bus            xform_lane_scheduler_if.master (residual in, lanes, coeff out)
//   lane_busy_cnt  per-lane outstanding block count, 4 bits per lane
//                  (only when XFORM_LANE_STATS_EN is defined)
//
// Build option
//   XFORM_LANE_STATS_EN : adds the lane_busy_cnt statistics counters.
//
// Dispatch states
//   state | meaning
//   IDLE  | waiting for a block's first beat; blocked while size FIFO is full
//   SEND  | streaming remaining beats of the current block to lane dp
module xform_lane_scheduler #(
  parameter int NUM_LANES = 2,
  parameter int IN_W      = 288,
  parameter int OUT_W     = 512,
  parameter int MAX_OUTST = 8
) (
  input  logic                    clk,
  input  logic                    arst_n,
  xform_lane_scheduler_if.master  bus
`ifdef XFORM_LANE_STATS_EN
  ,
  output logic [NUM_LANES*4-1:0]  lane_busy_cnt
`endif
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int FW = $clog2(MAX_OUTST);
  localparam logic [FW:0] FIFO_FULL_CNT = MAX_OUTST[FW:0];

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Index of the last beat of a block, input and output side.
  function automatic logic [5:0] in_last_idx(input logic [1:0] code);
    case (code)
      2'd0:    return 6'd0;
      2'd1:    return 6'd3;
      2'd2:    return 6'd15;
      default: return 6'd63;
    endcase
  endfunction

  function automatic logic [4:0] out_last_idx(input logic [1:0] code);
    case (code)
      2'd0:    return 5'd0;
      2'd1:    return 5'd1;
      2'd2:    return 5'd7;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [LW-1:0] next_lane(input logic [LW-1:0] p);
    return (p == LW'(NUM_LANES - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [0:0]    state_q, state_d;
  logic [LW-1:0] dp_q, dp_d;
  logic [LW-1:0] cp_q, cp_d;
  logic [5:0]    in_cnt_q, in_cnt_d;
  logic [4:0]    out_cnt_q, out_cnt_d;
  logic [1:0]    code_q, code_d;

  logic [1:0]    fifo_mem_q [MAX_OUTST];
  logic [FW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW:0]   fifo_cnt_q;

  logic          fifo_full, fifo_empty;
  logic [1:0]    cur_code, head_code;
  logic          in_open, in_rdy, in_xfer, in_last, push;
  logic          out_open, out_vld, out_xfer, out_last;

  always_comb begin
    fifo_full  = (fifo_cnt_q == FIFO_FULL_CNT);
    fifo_empty = (fifo_cnt_q == '0);
    head_code  = fifo_mem_q[rd_ptr_q];

    // In IDLE the code is read straight off the first beat so a single-beat
    // block can complete in the same cycle it is accepted.
    cur_code = (state_q == ST_IDLE) ? bus.resid_in_rsc_dat[IN_W-1 -: 2] : code_q;

    // arst_n gates the steering so every output reads 0 while reset is held.
    in_open  = arst_n && !((state_q == ST_IDLE) && fifo_full);
    in_rdy   = in_open && bus.lane_resid_rsc_rdy[dp_q];
    in_xfer  = in_rdy && bus.resid_in_rsc_vld;
    in_last  = in_xfer && (in_cnt_q == in_last_idx(cur_code));
    push     = in_xfer && (state_q == ST_IDLE);

    out_open = arst_n && !fifo_empty;
    out_vld  = out_open && bus.lane_coeff_rsc_vld[cp_q];
    out_xfer = out_vld && bus.coeff_out_rsc_rdy;
    out_last = out_xfer && (out_cnt_q == out_last_idx(head_code));
  end

  always_comb begin
    bus.resid_in_rsc_rdy   = in_rdy;
    bus.lane_resid_rsc_vld = '0;
    bus.lane_resid_rsc_dat = '0;
    if (in_open) begin
      bus.lane_resid_rsc_vld[dp_q] = bus.resid_in_rsc_vld;
      bus.lane_resid_rsc_dat[int'(dp_q)*IN_W +: IN_W] = bus.resid_in_rsc_dat;
    end

    bus.coeff_out_rsc_vld  = out_vld;
    bus.coeff_out_rsc_dat  = '0;
    bus.lane_coeff_rsc_rdy = '0;
    if (out_open) begin
      bus.coeff_out_rsc_dat = bus.lane_coeff_rsc_dat[int'(cp_q)*OUT_W +: OUT_W];
      bus.lane_coeff_rsc_rdy[cp_q] = bus.coeff_out_rsc_rdy;
    end
  end

  always_comb begin
    state_d  = state_q;
    dp_d     = dp_q;
    in_cnt_d = in_cnt_q;
    code_d   = code_q;
    if (push) begin
      code_d = cur_code;
    end
    if (in_xfer) begin
      if (in_last) begin
        in_cnt_d = '0;
        dp_d     = next_lane(dp_q);
        state_d  = ST_IDLE;
      end else begin
        in_cnt_d = in_cnt_q + 6'd1;
        state_d  = ST_SEND;
      end
    end

    cp_d      = cp_q;
    out_cnt_d = out_cnt_q;
    if (out_xfer) begin
      if (out_last) begin
        out_cnt_d = '0;
        cp_d      = next_lane(cp_q);
      end else begin
        out_cnt_d = out_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      dp_q      <= '0;
      cp_q      <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      dp_q      <= dp_d;
      cp_q      <= cp_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      code_q    <= code_d;
    end
  end

  // Size FIFO. Push is never attempted when full because in_open is low then.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= cur_code;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (out_last) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, out_last})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef XFORM_LANE_STATS_EN
  logic [3:0]           busy_q [NUM_LANES];
  logic [3:0]           busy_d [NUM_LANES];
  logic [NUM_LANES-1:0] lane_inc, lane_dec;

  always_comb begin
    lane_inc = '0;
    lane_dec = '0;
    if (in_last) begin
      lane_inc[dp_q] = 1'b1;
    end
    if (out_last) begin
      lane_dec[cp_q] = 1'b1;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      busy_d[i] = busy_q[i];
      if (lane_inc[i] && !lane_dec[i] && (busy_q[i] != 4'hF)) begin
        busy_d[i] = busy_q[i] + 4'd1;
      end else if (lane_dec[i] && !lane_inc[i] && (busy_q[i] != 4'h0)) begin
        busy_d[i] = busy_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        busy_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        busy_q[i] <= busy_d[i];
      end
    end
  end

  always_comb begin
    lane_busy_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_busy_cnt[i*4 +: 4] = busy_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_xform_lane_scheduler.sv
// Bench for xform_lane_scheduler: plays the residual source, two transform
// lanes (which echo block id, lane and beat index into coefficient beats) and
// the downstream stage. Expected output beats are queued when a block is
// driven and compared as the merged stream delivers them.
module tb_xform_lane_scheduler;

  localparam int NUM_LANES = 2;
  localparam int IN_W      = 288;
  localparam int OUT_W     = 512;
  localparam int MAX_OUTST = 8;

  logic clk;
  logic arst_n;

  xform_lane_scheduler_if #(.NUM_LANES(NUM_LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

`ifdef XFORM_LANE_STATS_EN
  logic [NUM_LANES*4-1:0] lane_busy_cnt;
`endif

  xform_lane_scheduler #(
    .NUM_LANES(NUM_LANES), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
`ifdef XFORM_LANE_STATS_EN
    ,
    .lane_busy_cnt (lane_busy_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [OUT_W-1:0] sb [$];
  logic [17:0]      lane_pend [NUM_LANES][$];
  int               lane_in_cnt  [NUM_LANES];
  int               lane_out_cnt [NUM_LANES];
  logic [1:0]       lane_code    [NUM_LANES];
  logic [15:0]      lane_id      [NUM_LANES];
  int               lane_blk_rx  [NUM_LANES];
  int               lane_beat_rx [NUM_LANES];
  logic [NUM_LANES-1:0] lane_en;
  int               out_beats_seen = 0;
  int               blk_cnt = 0;
  int               next_id = 1;
  int               stall_cnt = 0;

  function automatic int in_beats(input logic [1:0] code);
    case (code)
      2'd0: return 1;
      2'd1: return 4;
      2'd2: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int out_beats(input logic [1:0] code);
    case (code)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] mk_coeff(input int id, input int lane, input int beat);
    logic [OUT_W-1:0] c;
    c = '0;
    c[15:0]            = id[15:0];
    c[19:16]           = lane[3:0];
    c[27:20]           = beat[7:0];
    c[OUT_W-1 -: 16]   = ~id[15:0];
    return c;
  endfunction

  function automatic logic [IN_W-1:0] mk_resid(input logic [1:0] code, input int id, input int beat);
    logic [IN_W-1:0] r;
    logic [31:0]     rnd;
    rnd = $urandom;
    r = '0;
    r[15:0]          = id[15:0];
    r[23:16]         = beat[7:0];
    r[IN_W-3 -: 8]   = rnd[7:0];
    r[IN_W-1 -: 2]   = code;
    return r;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane models and output monitor: sample at negedge, drive #1 after posedge.
  logic [IN_W-1:0]  mon_rd;
  logic [17:0]      mon_hd;
  logic [OUT_W-1:0] mon_exp;
  initial begin : lane_proc
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.lane_resid_rsc_vld[i] && bus.lane_resid_rsc_rdy[i]) begin
          mon_rd = bus.lane_resid_rsc_dat[i*IN_W +: IN_W];
          if (lane_in_cnt[i] == 0) begin
            lane_code[i] = mon_rd[IN_W-1 -: 2];
            lane_id[i]   = mon_rd[15:0];
          end
          lane_beat_rx[i]++;
          lane_in_cnt[i]++;
          if (lane_in_cnt[i] == in_beats(lane_code[i])) begin
            lane_pend[i].push_back({lane_code[i], lane_id[i]});
            lane_in_cnt[i] = 0;
            lane_blk_rx[i]++;
          end
        end
        if (bus.lane_coeff_rsc_vld[i] && bus.lane_coeff_rsc_rdy[i] && lane_pend[i].size() > 0) begin
          mon_hd = lane_pend[i][0];
          lane_out_cnt[i]++;
          if (lane_out_cnt[i] == out_beats(mon_hd[17:16])) begin
            void'(lane_pend[i].pop_front());
            lane_out_cnt[i] = 0;
          end
        end
      end
      if (bus.coeff_out_rsc_vld && bus.coeff_out_rsc_rdy) begin
        out_beats_seen++;
        if (sb.size() == 0) begin
          check("out_beat_unexpected", 512'(sb.size()), 512'd1);
        end else begin
          mon_exp = sb.pop_front();
          check("coeff_out", bus.coeff_out_rsc_dat, mon_exp);
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_pend[i].size() > 0 && lane_en[i]) begin
          mon_hd = lane_pend[i][0];
          bus.lane_coeff_rsc_vld[i] = 1'b1;
          bus.lane_coeff_rsc_dat[i*OUT_W +: OUT_W] = mk_coeff(int'(mon_hd[15:0]), i, lane_out_cnt[i]);
        end else begin
          bus.lane_coeff_rsc_vld[i] = 1'b0;
          bus.lane_coeff_rsc_dat[i*OUT_W +: OUT_W] = '0;
        end
      end
    end
  end

  // Drives up to lim beats of a block; expected output beats are queued first.
  task automatic send_block(input logic [1:0] code, input int lim);
    int  id;
    int  exp_lane;
    bit  done;
    id       = next_id;
    next_id++;
    exp_lane = blk_cnt % NUM_LANES;
    blk_cnt++;
    for (int b = 0; b < out_beats(code); b++) begin
      sb.push_back(mk_coeff(id, exp_lane, b));
    end
    for (int b = 0; b < in_beats(code) && b < lim; b++) begin
      bus.resid_in_rsc_dat = mk_resid((b == 0) ? code : 2'($urandom_range(0, 3)), id, b);
      bus.resid_in_rsc_vld = 1'b1;
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
        @(negedge clk);
        if (bus.resid_in_rsc_rdy) done = 1'b1;
        else stall_cnt++;
        @(posedge clk);
        #1;
      end
      if (!done) begin
        check("send_timeout", 512'(done), 512'd1);
        b = in_beats(code);
      end
    end
    bus.resid_in_rsc_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    check({tag, "_left"}, 512'(sb.size()), 512'd0);
    @(negedge clk);
    check({tag, "_vld_idle"}, 512'(bus.coeff_out_rsc_vld), 512'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  base0, base1, beats0, outs0, viol, hold_hits;
  bit  got;

  initial begin : main
    arst_n = 1'b0;
    bus.resid_in_rsc_dat   = '0;
    bus.resid_in_rsc_vld   = 1'b0;
    bus.lane_resid_rsc_rdy = '1;
    bus.lane_coeff_rsc_dat = '0;
    bus.lane_coeff_rsc_vld = '0;
    bus.coeff_out_rsc_rdy  = 1'b1;
    lane_en = '1;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_in_cnt[i] = 0; lane_out_cnt[i] = 0; lane_blk_rx[i] = 0; lane_beat_rx[i] = 0;
      lane_code[i] = '0; lane_id[i] = '0;
    end

    #3;
    check("rst_resid_rdy",  512'(bus.resid_in_rsc_rdy),   512'd0);
    check("rst_lane_vld",   512'(bus.lane_resid_rsc_vld), 512'd0);
    check("rst_coeff_vld",  512'(bus.coeff_out_rsc_vld),  512'd0);
    check("rst_coeff_rdy",  512'(bus.lane_coeff_rsc_rdy), 512'd0);
    check("rst_coeff_dat",  bus.coeff_out_rsc_dat,        512'd0);
`ifdef XFORM_LANE_STATS_EN
    check("rst_busy", 512'(lane_busy_cnt), 512'd0);
`endif
    repeat (2) @(posedge clk);
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four 4x4 blocks back to back.
    stall_cnt = 0;
    repeat (4) send_block(2'd0, 64);
    check("t1_no_stall", 512'(stall_cnt), 512'd0);
    check("t1_lane0_blocks", 512'(lane_blk_rx[0]), 512'd2);
    check("t1_lane1_blocks", 512'(lane_blk_rx[1]), 512'd2);
    drain("t1");
    check("t1_out_beats", 512'(out_beats_seen), 512'd4);

    // One 32x32 block.
    beats0 = lane_beat_rx[0];
    outs0  = out_beats_seen;
    send_block(2'd3, 64);
    check("t2_lane0_beats", 512'(lane_beat_rx[0] - beats0), 512'd64);
    drain("t2");
    check("t2_out_beats", 512'(out_beats_seen - outs0), 512'd32);

    // Filler goes to lane 1 (dp advanced), then lane 1 finishes before lane 0.
    send_block(2'd0, 64);
    drain("t3_fill");
    lane_en[0] = 1'b0;
    send_block(2'd0, 64);
    send_block(2'd1, 64);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.coeff_out_rsc_vld || bus.lane_coeff_rsc_rdy[1]) viol++;
      @(posedge clk);
      #1;
    end
    check("t3_hold_viol", 512'(viol), 512'd0);
    check("t3_lane1_ready", 512'(bus.lane_coeff_rsc_vld[1]), 512'd1);
    lane_en[0] = 1'b1;
    drain("t3");

    // Fill the size FIFO with downstream stalled.
    bus.coeff_out_rsc_rdy = 1'b0;
    base0 = lane_blk_rx[0];
    base1 = lane_blk_rx[1];
    repeat (8) send_block(2'd0, 64);
    check("t4_dispatched", 512'((lane_blk_rx[0] - base0) + (lane_blk_rx[1] - base1)), 512'd8);
    bus.resid_in_rsc_dat = mk_resid(2'd0, next_id, 0);
    bus.resid_in_rsc_vld = 1'b1;
    hold_hits = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resid_in_rsc_rdy || (|bus.lane_resid_rsc_vld)) hold_hits++;
      @(posedge clk);
      #1;
    end
    check("t4_full_blocks", 512'(hold_hits), 512'd0);
    bus.resid_in_rsc_vld  = 1'b0;
    bus.coeff_out_rsc_rdy = 1'b1;
    send_block(2'd0, 64);
    drain("t4");
    check("t4_ninth_dispatched",
          512'((lane_blk_rx[0] - base0) + (lane_blk_rx[1] - base1)), 512'd9);

    // Reset in the middle of a 16x16 block, with beat 7 presented.
    send_block(2'd2, 7);
    bus.resid_in_rsc_dat = mk_resid(2'($urandom_range(0, 3)), next_id - 1, 7);
    bus.resid_in_rsc_vld = 1'b1;
    #1 arst_n = 1'b0;
    #1;
    check("mid_rst_resid_rdy", 512'(bus.resid_in_rsc_rdy),   512'd0);
    check("mid_rst_lane_vld",  512'(bus.lane_resid_rsc_vld), 512'd0);
    check("mid_rst_lane_dat",  512'(|bus.lane_resid_rsc_dat), 512'd0);
    check("mid_rst_coeff_vld", 512'(bus.coeff_out_rsc_vld),  512'd0);
    check("mid_rst_coeff_rdy", 512'(bus.lane_coeff_rsc_rdy), 512'd0);
`ifdef XFORM_LANE_STATS_EN
    check("mid_rst_busy", 512'(lane_busy_cnt), 512'd0);
`endif
    bus.resid_in_rsc_vld = 1'b0;
    sb.delete();
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_pend[i].delete();
      lane_in_cnt[i]  = 0;
      lane_out_cnt[i] = 0;
    end
    blk_cnt = 0;
    repeat (3) @(posedge clk);
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;
    base0 = lane_blk_rx[0];
    send_block(2'd0, 64);
    check("t5_lane0_after_rst", 512'(lane_blk_rx[0] - base0), 512'd1);
    drain("t5");

    // Filler to lane 1 brings dp back to 0, then three blocks uncollected.
    send_block(2'd0, 64);
    drain("t6_fill");
    bus.coeff_out_rsc_rdy = 1'b0;
    send_block(2'd0, 64);
    send_block(2'd1, 64);
    send_block(2'd0, 64);
    @(negedge clk);
`ifdef XFORM_LANE_STATS_EN
    check("t6_busy_3", 512'(lane_busy_cnt), 512'h12);
`endif
    check("t6_stalled_vld", 512'(bus.coeff_out_rsc_vld), 512'd1);
    @(posedge clk);
    #1;
    bus.coeff_out_rsc_rdy = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (bus.coeff_out_rsc_vld) got = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.coeff_out_rsc_rdy = 1'b0;
    check("t6_one_collected", 512'(got), 512'd1);
    @(negedge clk);
`ifdef XFORM_LANE_STATS_EN
    check("t6_busy_after_one", 512'(lane_busy_cnt), 512'h11);
`endif
    @(posedge clk);
    #1;
    bus.coeff_out_rsc_rdy = 1'b1;
    drain("t6");
`ifdef XFORM_LANE_STATS_EN
    check("t6_busy_drained", 512'(lane_busy_cnt), 512'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
